// File: rtl/knap_pkg.sv
// Shared constants, item table and FSM state type for the
// multi-knapsack solver.
package knap_pkg;

    localparam int N_ITEMS = 5;
    localparam int SUM_W   = 8;

    // Index 0 is item A, index 4 is item E.
    localparam logic [SUM_W-1:0] ITEM_VALUE [N_ITEMS] = '{
        SUM_W'(4), SUM_W'(2), SUM_W'(2), SUM_W'(1), SUM_W'(10)
    };
    localparam logic [SUM_W-1:0] ITEM_WEIGHT [N_ITEMS] = '{
        SUM_W'(12), SUM_W'(1), SUM_W'(2), SUM_W'(1), SUM_W'(4)
    };
    localparam logic [SUM_W-1:0] ITEM_VOLUME [N_ITEMS] = '{
        SUM_W'(1), SUM_W'(1), SUM_W'(1), SUM_W'(1), SUM_W'(1)
    };

    localparam logic [SUM_W-1:0] DEF_MIN_VALUE  = SUM_W'(15);
    localparam logic [SUM_W-1:0] DEF_MAX_WEIGHT = SUM_W'(16);
    localparam logic [SUM_W-1:0] DEF_MAX_VOLUME = SUM_W'(10);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_EMIT,
        ST_DONE
    } state_t;

endpackage

// File: rtl/multi_knapsack_solver_if.sv
// Control, limit and solution-stream bundle of the solver.
// slave = solver side, master = requester side.
interface multi_knapsack_solver_if #(
    parameter int N_ITEMS = 5,
    parameter int SUM_W   = 8
);
    logic               start;
    logic [SUM_W-1:0]   min_value;
    logic [SUM_W-1:0]   max_weight;
    logic [SUM_W-1:0]   max_volume;
    logic               busy;
    logic               sol_valid;
    logic               sol_ready;
    logic [N_ITEMS-1:0] sol_sel;
    logic [SUM_W-1:0]   sol_value;
    logic               done;
    logic [5:0]         sol_count;
    logic [N_ITEMS-1:0] best_sel;
    logic [SUM_W-1:0]   best_value;

    modport master (
        output start, min_value, max_weight, max_volume, sol_ready,
        input  busy, sol_valid, sol_sel, sol_value, done, sol_count,
        input  best_sel, best_value
    );

    modport slave (
        input  start, min_value, max_weight, max_volume, sol_ready,
        output busy, sol_valid, sol_sel, sol_value, done, sol_count,
        output best_sel, best_value
    );

endinterface

// File: rtl/knap_eval.sv
// Combinational evaluation of one candidate selection:
// value/weight/volume sums and the validity test.
module knap_eval
    import knap_pkg::*;
(
    input  logic [N_ITEMS-1:0] sel,
    input  logic [SUM_W-1:0]   min_value,
    input  logic [SUM_W-1:0]   max_weight,
    input  logic [SUM_W-1:0]   max_volume,
    output logic [SUM_W-1:0]   value,
    output logic [SUM_W-1:0]   weight,
    output logic [SUM_W-1:0]   volume,
    output logic               valid
);

    // Accumulate the attributes of every selected item.
    always_comb begin
        value  = '0;
        weight = '0;
        volume = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (sel[i]) begin
                value  = value + ITEM_VALUE[i];
                weight = weight + ITEM_WEIGHT[i];
                volume = volume + ITEM_VOLUME[i];
            end
        end
    end

    assign valid = (value >= min_value)
                && (weight <= max_weight)
                && (volume <= max_volume);

endmodule

// File: rtl/multi_knapsack_solver.sv
// Exhaustive knapsack search streaming every valid selection.
// Define KNAP_BEST_TRACK_EN to enable best-solution tracking.
module multi_knapsack_solver #(
    parameter int N_ITEMS = 5,
    parameter int SUM_W   = 8
) (
    input logic                    clk,
    input logic                    rst_n,
    multi_knapsack_solver_if.slave bus
);
    import knap_pkg::*;

    state_t             state_q;
    state_t             state_d;
    logic [N_ITEMS-1:0] cand_q;
    logic [SUM_W-1:0]   min_q;
    logic [SUM_W-1:0]   wt_q;
    logic [SUM_W-1:0]   vol_q;
    logic               sol_valid_q;
    logic [N_ITEMS-1:0] sol_sel_q;
    logic [SUM_W-1:0]   sol_value_q;
    logic [5:0]         sol_count_q;

    logic [SUM_W-1:0]   ev_value;
    logic [SUM_W-1:0]   ev_weight;
    logic [SUM_W-1:0]   ev_volume;
    logic               ev_valid;
    logic               last;
    logic               hs;
    logic               unused_sums;

    knap_eval u_eval (
        .sel        (cand_q),
        .min_value  (min_q),
        .max_weight (wt_q),
        .max_volume (vol_q),
        .value      (ev_value),
        .weight     (ev_weight),
        .volume     (ev_volume),
        .valid      (ev_valid)
    );

    assign unused_sums = ^{ev_weight, ev_volume};
    assign last        = &cand_q;
    assign hs          = sol_valid_q & bus.sol_ready;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (ev_valid)  state_d = ST_EMIT;
                else if (last) state_d = ST_DONE;
            end
            ST_EMIT: begin
                if (hs) state_d = last ? ST_DONE : ST_RUN;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Limits, candidate counter and the solution output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q      <= '0;
            min_q       <= '0;
            wt_q        <= '0;
            vol_q       <= '0;
            sol_valid_q <= 1'b0;
            sol_sel_q   <= '0;
            sol_value_q <= '0;
            sol_count_q <= '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        min_q       <= bus.min_value;
                        wt_q        <= bus.max_weight;
                        vol_q       <= bus.max_volume;
                        cand_q      <= '0;
                        sol_count_q <= '0;
                    end
                end
                ST_RUN: begin
                    if (ev_valid) begin
                        sol_sel_q   <= cand_q;
                        sol_value_q <= ev_value;
                        sol_valid_q <= 1'b1;
                        sol_count_q <= sol_count_q + 6'd1;
                    end else if (!last) begin
                        cand_q <= cand_q + N_ITEMS'(1);
                    end
                end
                ST_EMIT: begin
                    if (hs) begin
                        sol_valid_q <= 1'b0;
                        if (!last) cand_q <= cand_q + N_ITEMS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef KNAP_BEST_TRACK_EN
    logic [N_ITEMS-1:0] best_sel_q;
    logic [SUM_W-1:0]   best_value_q;
    logic               best_found_q;

    // Keep the earliest strictly highest-value valid candidate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            best_sel_q   <= '0;
            best_value_q <= '0;
            best_found_q <= 1'b0;
        end else if (state_q == ST_IDLE && bus.start) begin
            best_sel_q   <= '0;
            best_value_q <= '0;
            best_found_q <= 1'b0;
        end else if (state_q == ST_RUN && ev_valid
                     && (!best_found_q || ev_value > best_value_q)) begin
            best_sel_q   <= cand_q;
            best_value_q <= ev_value;
            best_found_q <= 1'b1;
        end
    end

    assign bus.best_sel   = best_sel_q;
    assign bus.best_value = best_value_q;
`else
    assign bus.best_sel   = '0;
    assign bus.best_value = '0;
`endif

    assign bus.busy      = (state_q == ST_RUN) || (state_q == ST_EMIT);
    assign bus.done      = (state_q == ST_DONE);
    assign bus.sol_valid = sol_valid_q;
    assign bus.sol_sel   = sol_sel_q;
    assign bus.sol_value = sol_value_q;
    assign bus.sol_count = sol_count_q;

endmodule

// File: tb/tb_multi_knapsack_solver.sv
// Self-checking bench for multi_knapsack_solver: vector table,
// randomized limits/backpressure against a reference model, reset.
`timescale 1ns/1ps
module tb_multi_knapsack_solver;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    multi_knapsack_solver_if #(.N_ITEMS(5), .SUM_W(8)) bus ();

    multi_knapsack_solver #(.N_ITEMS(5), .SUM_W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: brute force over all 32 subsets.
    int iv [5] = '{4, 2, 2, 1, 10};
    int iw [5] = '{12, 1, 2, 1, 4};
    int exp_sel [$];
    int exp_val [$];
    int m_best_sel;
    int m_best_val;

    function automatic void build_model(input int mn, input int wt, input int vl);
        exp_sel.delete();
        exp_val.delete();
        m_best_sel = 0;
        m_best_val = -1;
        for (int s = 0; s < 32; s++) begin
            int v;
            int w;
            int c;
            v = 0;
            w = 0;
            c = 0;
            for (int i = 0; i < 5; i++) begin
                if (((s >> i) & 1) == 1) begin
                    v += iv[i];
                    w += iw[i];
                    c += 1;
                end
            end
            if (v >= mn && w <= wt && c <= vl) begin
                exp_sel.push_back(s);
                exp_val.push_back(v);
                if (v > m_best_val) begin
                    m_best_val = v;
                    m_best_sel = s;
                end
            end
        end
        if (m_best_val < 0) m_best_val = 0;
    endfunction

    function automatic int gate_best(input int v);
`ifdef KNAP_BEST_TRACK_EN
        return v;
`else
        return 0 * v;
`endif
    endfunction

    int got_sel [$];
    int got_val [$];
    int done_cyc;

    task automatic run_search(input int mn, input int wt, input int vl,
                              input bit rnd_ready, input int stall);
        int  stall_left;
        bit  seen_done;
        bit  prev_valid;
        bit  prev_r;
        int  prev_sel;
        int  prev_val;
        bit  r;
        int  busy_bad;
        int  stab_bad;
        stall_left = stall;
        seen_done  = 1'b0;
        prev_valid = 1'b0;
        prev_r     = 1'b0;
        prev_sel   = 0;
        prev_val   = 0;
        busy_bad   = 0;
        stab_bad   = 0;
        got_sel.delete();
        got_val.delete();
        done_cyc = -1;
        build_model(mn, wt, vl);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.min_value  = 8'(mn);
        bus.max_weight = 8'(wt);
        bus.max_volume = 8'(vl);
        bus.sol_ready  = 1'b0;
        for (int k = 1; k <= 600 && !seen_done; k++) begin
            @(negedge clk);
            bus.start = (k == 5);
            if (bus.sol_valid && prev_valid && !prev_r) begin
                if (int'(bus.sol_sel) != prev_sel ||
                    int'(bus.sol_value) != prev_val) stab_bad++;
            end
            if (rnd_ready) begin
                r = 1'($urandom_range(0, 1));
            end else if (bus.sol_valid && stall_left > 0) begin
                r = 1'b0;
                stall_left--;
            end else begin
                r = 1'b1;
            end
            bus.sol_ready = r;
            if (bus.sol_valid && r) begin
                got_sel.push_back(int'(bus.sol_sel));
                got_val.push_back(int'(bus.sol_value));
            end
            prev_valid = bus.sol_valid;
            prev_r     = r;
            prev_sel   = int'(bus.sol_sel);
            prev_val   = int'(bus.sol_value);
            if (bus.done) begin
                seen_done = 1'b1;
                done_cyc  = k;
                if (bus.busy) busy_bad++;
                bus.start = 1'b1;
            end else if (!bus.busy) begin
                busy_bad++;
            end
        end
        if (!seen_done) chk("done_timeout", 0, 1);
        @(negedge clk);
        bus.start     = 1'b0;
        bus.sol_ready = 1'b0;
        chk("done_one_cycle", int'(bus.done), 0);
        chk("idle_after_done", int'(bus.busy), 0);
        chk("busy_during_search", busy_bad, 0);
        chk("sol_stable_stall", stab_bad, 0);
        chk("sol_num", got_sel.size(), exp_sel.size());
        for (int i = 0; i < got_sel.size() && i < exp_sel.size(); i++) begin
            chk("sol_sel", got_sel[i], exp_sel[i]);
            chk("sol_value", got_val[i], exp_val[i]);
        end
        chk("sol_count_model", int'(bus.sol_count), exp_sel.size());
        chk("best_sel_model", int'(bus.best_sel), gate_best(m_best_sel));
        chk("best_value_model", int'(bus.best_value), gate_best(m_best_val));
    endtask

    typedef struct {
        int mn;
        int wt;
        int vl;
        int cnt;
        int bsel;
        int bval;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int d0;
        int d1;
        int hs_seen;
        int nodone_bad;
        bit hit;

        tbl[0] = '{15, 16, 10, 1, 30, 15};
        tbl[1] = '{0, 255, 10, 32, 31, 19};
        tbl[2] = '{0, 255, 2, 16, 17, 14};
        tbl[3] = '{255, 255, 10, 0, 0, 0};

        rst_n          = 1'b0;
        bus.start      = 1'b0;
        bus.min_value  = '0;
        bus.max_weight = '0;
        bus.max_volume = '0;
        bus.sol_ready  = 1'b0;
        #1;
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_done", int'(bus.done), 0);
        chk("rst_sol_valid", int'(bus.sol_valid), 0);
        chk("rst_sol_count", int'(bus.sol_count), 0);
        chk("rst_best_sel", int'(bus.best_sel), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vector table, sol_ready held high.
        for (int t = 0; t < 4; t++) begin
            run_search(tbl[t].mn, tbl[t].wt, tbl[t].vl, 1'b0, 0);
            chk("tbl_sol_count", int'(bus.sol_count), tbl[t].cnt);
            chk("tbl_best_sel", int'(bus.best_sel), gate_best(tbl[t].bsel));
            chk("tbl_best_value", int'(bus.best_value), gate_best(tbl[t].bval));
            if (t == 0 && got_sel.size() > 0) chk("tbl_first_sel", got_sel[0], 30);
            if (t == 3) chk("zero_sol_done_cycle", done_cyc, 33);
        end

        // Backpressure: ten stalled cycles delay done by ten.
        run_search(15, 16, 10, 1'b0, 0);
        d0 = done_cyc;
        run_search(15, 16, 10, 1'b0, 10);
        d1 = done_cyc;
        chk("stall_done_delay", d1 - d0, 10);

        // Random limits and random sol_ready.
        for (int r = 0; r < 8; r++) begin
            run_search(int'($urandom_range(0, 20)), int'($urandom_range(0, 40)),
                       int'($urandom_range(0, 5)), 1'b1, 0);
        end

        // Reset during EMIT abandons the search.
        @(negedge clk);
        bus.start      = 1'b1;
        bus.min_value  = 8'd0;
        bus.max_weight = 8'd255;
        bus.max_volume = 8'd10;
        bus.sol_ready  = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        hs_seen   = 0;
        hit       = 1'b0;
        for (int k = 0; k < 200 && !hit; k++) begin
            if (bus.sol_valid && hs_seen == 3) begin
                hit = 1'b1;
            end else begin
                bus.sol_ready = 1'b1;
                if (bus.sol_valid) hs_seen++;
                @(negedge clk);
            end
        end
        chk("reset_emit_reached", int'(hit), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_sol_valid", int'(bus.sol_valid), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_done", int'(bus.done), 0);
        chk("midrst_sol_sel", int'(bus.sol_sel), 0);
        chk("midrst_sol_value", int'(bus.sol_value), 0);
        chk("midrst_sol_count", int'(bus.sol_count), 0);
        chk("midrst_best_value", int'(bus.best_value), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        nodone_bad = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.sol_valid) nodone_bad++;
        end
        chk("no_done_after_reset", nodone_bad, 0);

        run_search(tbl[1].mn, tbl[1].wt, tbl[1].vl, 1'b0, 0);
        chk("post_rst_sol_count", int'(bus.sol_count), 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
